tdm_demux: RTL

//  Receive end of a time-division-multiplexed link: one W-bit sample per valid

---
 rtl/tdm_pkg.sv | 10 +
 rtl/demux_1_to_n.sv | 19 +
 rtl/tdm_demux.sv | 117 +++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the TDM receive path.
// Only the demux FSM state encoding lives here.
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT,
    COLLECT
  } state_e;

endpackage

// File: rtl/demux_1_to_n.sv
// Combinational 1-to-N demux: turns a lane select into one-hot write-enables.
// This is the inverse of the TDM mux and is used to steer samples to lanes.
module demux_1_to_n #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned SelW    = $clog2(N_LANES)
) (
  input  logic [SelW-1:0]    sel,
  input  logic               en,
  output logic [N_LANES-1:0] we
);

  always_comb begin
    we = '0;
    for (int k = 0; k < N_LANES; k++) begin
      we[k] = en && (sel == SelW'(k));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: steers one sample per valid cycle into lane registers and
// presents each complete frame in parallel with a one-cycle out_valid pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  output logic [N_LANES*W-1:0] out_data,
  output logic                 out_err
);

  localparam int unsigned CntW = $clog2(N_LANES);

  state_e               state_q, state_d;
  logic [CntW-1:0]      lane_cnt_q, lane_cnt_d;
  logic [CntW-1:0]      wr_sel;
  logic                 wr_en;
  logic [N_LANES-1:0]   wr_we;
  logic [W-1:0]         lane_q [N_LANES];
  logic [N_LANES*W-1:0] frame;
  logic [N_LANES*W-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_err_q, out_err_d;

  demux_1_to_n #(
    .N_LANES (N_LANES),
    .SelW    (CntW)
  ) u_lane_demux (
    .sel (wr_sel),
    .en  (wr_en),
    .we  (wr_we)
  );

  // Frame as it will look once this cycle's sample lands in its lane.
  always_comb begin
    frame = '0;
    for (int k = 0; k < N_LANES; k++) begin
      frame[k*W +: W] = wr_we[k] ? in_data : lane_q[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    wr_sel      = '0;
    wr_en       = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_err_d   = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (in_valid && in_sof) begin
          wr_en      = 1'b1;
          lane_cnt_d = CntW'(1);
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid && in_sof) begin
          // Early sof: drop the partial frame and restart on this sample.
          wr_en      = 1'b1;
          lane_cnt_d = CntW'(1);
          out_err_d  = 1'b1;
        end else if (in_valid) begin
          wr_sel = lane_cnt_q;
          wr_en  = 1'b1;
          if (lane_cnt_q == CntW'(N_LANES - 1)) begin
            out_data_d  = frame;
            out_valid_d = 1'b1;
            lane_cnt_d  = '0;
            state_d     = HUNT;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      lane_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      for (int k = 0; k < N_LANES; k++) begin
        if (wr_we[k]) begin
          lane_q[k] <= in_data;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
